// File: rtl/receptor_serial.sv
`default_nettype none
// ============================================================================
// Module   : receptor_serial
// Brief    : Framed serial receiver (start, N data, optional even parity, stop)
//            with DIR-selectable bit order, VALID/ERR strobes and BUSY flag.
// Revision : 1.0
// ============================================================================
module receptor_serial #(
    parameter int N      = 4,
    parameter int PARITY = 0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ENB,
    input  logic         DIR,
    input  logic         S_IN,
    output logic [N-1:0] Q,
    output logic         VALID,
    output logic         ERR,
    output logic         BUSY
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [N-1:0]     r_shift, w_shift_nxt;
    logic             r_dir,   w_dir_nxt;
    logic             r_perr,  w_perr_nxt;
    logic [N-1:0]     r_q,     w_q_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_err,   w_err_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_dir   <= 1'b0;
            r_perr  <= 1'b0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_dir   <= w_dir_nxt;
            r_perr  <= w_perr_nxt;
            r_q     <= w_q_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Strobes default low so they last one CLK cycle even when ENB is sparse.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_dir_nxt   = r_dir;
        w_perr_nxt  = r_perr;
        w_q_nxt     = r_q;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        if (ENB) begin
            case (r_state)
                ST_IDLE: begin
                    if (!S_IN) begin
                        w_state_nxt = ST_DATA;
                        w_dir_nxt   = DIR;
                        w_cnt_nxt   = '0;
                        w_shift_nxt = '0;
                        w_perr_nxt  = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (r_dir) begin
                        w_shift_nxt = {r_shift[N-2:0], S_IN};
                    end else begin
                        w_shift_nxt = {S_IN, r_shift[N-1:1]};
                    end
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end
                end
                ST_PAR: begin
                    w_perr_nxt  = (^r_shift) ^ S_IN;
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    // A low stop bit is a framing error, never a new start bit.
                    w_state_nxt = ST_IDLE;
                    if (S_IN && !r_perr) begin
                        w_q_nxt     = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign Q     = r_q;
    assign VALID = r_valid;
    assign ERR   = r_err;
    assign BUSY  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_receptor_serial.sv
`default_nettype none
// Directed bench for receptor_serial: one no-parity and one even-parity instance.
module tb_receptor_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b1;
    logic       dir = 1'b0;
    logic       s_in0 = 1'b1;
    logic       s_in1 = 1'b1;
    logic [3:0] q0, q1;
    logic       valid0, err0, busy0;
    logic       valid1, err1, busy1;
    int         total = 0;
    int         bad = 0;
    logic [0:5] fr6;
    logic [0:6] fr7;

    always #5 clk = ~clk;

    receptor_serial #(.N(4), .PARITY(0)) dut0 (
        .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(s_in0),
        .Q(q0), .VALID(valid0), .ERR(err0), .BUSY(busy0)
    );

    receptor_serial #(.N(4), .PARITY(1)) dut1 (
        .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(s_in1),
        .Q(q1), .VALID(valid1), .ERR(err1), .BUSY(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample slot with ENB pulsed: enabled edge, then two idle cycles.
    task automatic slow_bit(input logic b);
        s_in0 = b;
        enb   = 1'b1;
        tick();
        enb   = 1'b0;
    endtask

    initial begin
        tick();
        chk("reset_q", {4'h0, q0}, 8'h0);
        chk("reset_valid", {7'h0, valid0}, 8'h0);
        chk("reset_err", {7'h0, err0}, 8'h0);
        chk("reset_busy", {7'h0, busy0}, 8'h0);
        rst = 1'b0;
        tick();

        // Test 1: LSB first, 0,1,1,0,1,1 -> 4'hB on the 6th edge.
        fr6 = 6'b011011;
        for (int i = 0; i < 6; i++) begin
            s_in0 = fr6[i];
            tick();
            if (i < 5) begin
                chk("t1_busy", {7'h0, busy0}, 8'h1);
                chk("t1_no_valid", {7'h0, valid0}, 8'h0);
            end
        end
        chk("t1_q", {4'h0, q0}, 8'h0B);
        chk("t1_valid", {7'h0, valid0}, 8'h1);
        chk("t1_busy_fall", {7'h0, busy0}, 8'h0);
        s_in0 = 1'b1;
        tick();
        chk("t1_valid_1cyc", {7'h0, valid0}, 8'h0);

        // Test 2: same stream, MSB first -> 4'hD.
        dir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_in0 = fr6[i];
            tick();
            if (i == 1) dir = 1'b0;
        end
        chk("t2_q", {4'h0, q0}, 8'h0D);
        chk("t2_valid", {7'h0, valid0}, 8'h1);
        s_in0 = 1'b1;
        tick();

        // Test 3: even parity, data B (d0..d3 = 1,1,0,1), parity 1 then 0.
        dir = 1'b0;
        fr7 = 7'b0110111;
        for (int i = 0; i < 7; i++) begin
            s_in1 = fr7[i];
            tick();
            if (i == 5) chk("t3_busy_par", {7'h0, busy1}, 8'h1);
        end
        chk("t3_q_good", {4'h0, q1}, 8'h0B);
        chk("t3_valid_good", {7'h0, valid1}, 8'h1);
        chk("t3_err_good", {7'h0, err1}, 8'h0);
        fr7 = 7'b0110101;
        for (int i = 0; i < 7; i++) begin
            s_in1 = fr7[i];
            tick();
        end
        chk("t3_err_bad", {7'h0, err1}, 8'h1);
        chk("t3_valid_bad", {7'h0, valid1}, 8'h0);
        chk("t3_q_held", {4'h0, q1}, 8'h0B);
        s_in1 = 1'b1;
        tick();
        chk("t3_err_1cyc", {7'h0, err1}, 8'h0);

        // Test 4: data 5 with stop bit 0, then idle line.
        fr6 = 6'b010100;
        for (int i = 0; i < 6; i++) begin
            s_in0 = fr6[i];
            tick();
        end
        chk("t4_err", {7'h0, err0}, 8'h1);
        chk("t4_valid", {7'h0, valid0}, 8'h0);
        chk("t4_q_held", {4'h0, q0}, 8'h0D);
        chk("t4_busy", {7'h0, busy0}, 8'h0);
        s_in0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_idle_busy", {7'h0, busy0}, 8'h0);
            chk("t4_idle_strobe", {6'h0, valid0, err0}, 8'h0);
        end

        // Test 5: ENB every 3rd cycle, back-to-back frames 3 then C.
        fr6 = 6'b011001;
        for (int i = 0; i < 6; i++) begin
            slow_bit(fr6[i]);
            if (i == 5) begin
                chk("t5a_q", {4'h0, q0}, 8'h03);
                chk("t5a_valid", {7'h0, valid0}, 8'h1);
            end
            tick();
            if (i == 5) chk("t5a_valid_1cyc", {7'h0, valid0}, 8'h0);
            if (i == 2) chk("t5a_busy_hold", {7'h0, busy0}, 8'h1);
            tick();
        end
        fr6 = 6'b000111;
        for (int i = 0; i < 6; i++) begin
            slow_bit(fr6[i]);
            if (i == 0) chk("t5b_busy_start", {7'h0, busy0}, 8'h1);
            if (i == 5) begin
                chk("t5b_q", {4'h0, q0}, 8'h0C);
                chk("t5b_valid", {7'h0, valid0}, 8'h1);
            end
            tick();
            if (i == 5) chk("t5b_valid_1cyc", {7'h0, valid0}, 8'h0);
            tick();
        end
        enb = 1'b1;
        s_in0 = 1'b1;
        tick();

        // Test 6: reset after the 2nd data bit of 9 (1,0,0,1), then resend 9.
        fr6 = 6'b010011;
        for (int i = 0; i < 3; i++) begin
            s_in0 = fr6[i];
            tick();
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_q", {4'h0, q0}, 8'h00);
        chk("t6_rst_busy", {7'h0, busy0}, 8'h0);
        chk("t6_rst_strobe", {6'h0, valid0, err0}, 8'h0);
        s_in0 = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_strobe", {6'h0, valid0, err0}, 8'h0);
        for (int i = 0; i < 6; i++) begin
            s_in0 = fr6[i];
            tick();
        end
        chk("t6_q", {4'h0, q0}, 8'h09);
        chk("t6_valid", {7'h0, valid0}, 8'h1);
        s_in0 = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/receptor_serial.md
# receptor_serial

Serial-to-parallel frame receiver: the receiving end of the serial line driven by the shift registers' `S_OUT`. It samples a framed bit stream on `S_IN` (start bit, N data bits, optional even-parity bit, stop bit) and reassembles the N-bit word, honouring the same `DIR` bit-order convention as the shift registers. It presents the word on `Q` with a one-cycle `VALID` strobe, and flags framing or parity faults on `ERR`. It sits beside the register under test in the testbench, so the tester can check the serial path end to end.

## Interface
- `N`, default 4: data word width in bits (N ≥ 2).
- `PARITY`, default 0:
  - 1: an even-parity bit follows the data bits.
  - 0: no parity bit.

- `CLK`, input, 1: system clock. All state updates on the rising edge.
- `RST`, input, 1: asynchronous, active-high reset.
- `ENB`, input, 1: bit-sample enable. The line is sampled only on rising edges where `ENB`=1.
- `DIR`, input, 1: bit order. Latched when the start bit is detected.
  - 0: LSB first.
  - 1: MSB first.
- `S_IN`, input, 1: serial line. It idles at 1.
- `Q`, output, N: last correctly received word.
- `VALID`, output, 1: one-cycle strobe. High when `Q` has just been updated.
- `ERR`, output, 1: one-cycle strobe for a framing or parity error.
- `BUSY`, output, 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Every state register is updated only on sample edges, i.e. edges where `ENB`=1. The exceptions are `VALID` and `ERR`, which clear on the next edge regardless of `ENB`.
- Reset (asynchronous, while `RST`=1):
  - state is IDLE and the bit counter is 0;
  - `Q`=0, `VALID`=0, `ERR`=0, `BUSY`=0;
  - the shift register and the latched DIR are both 0.
- State machine:
  - IDLE: on a sample edge with `S_IN`=0, go to DATA. Latch `DIR`, clear the counter and shift register. Otherwise stay in IDLE.
  - DATA: on each sample edge, shift in `S_IN`.
    - DIR=0: the bit enters at the MSB end and the register shifts right, so the first bit ends up in bit 0.
    - DIR=1: the bit enters at bit 0 and the register shifts left, so the first bit ends up in bit N-1.
    - After the N-th data bit, go to PAR if `PARITY`=1, else go to STOP.
  - PAR: on a sample edge, store `parity_err = (^shift) ^ S_IN`, then go to STOP.
  - STOP: on a sample edge, return to IDLE.
    - If `S_IN`=1 and there is no parity error: `Q` ← shift register and `VALID`=1.
    - Otherwise: `ERR`=1 and `Q` is held.
- A 0 sampled in STOP is a framing error only. It is not treated as a new start bit.
- `DIR` changes mid-frame have no effect. The latched value applies until the next start bit.
- A stop-bit sample and a start-bit sample can never share an edge. The earliest next start bit is the next sample edge after STOP.
- `RST` asserted mid-frame aborts the frame: no `VALID`, no `ERR`, and `Q` is cleared to 0.
- The bit counter must be wide enough to count to N. No overflow or wrap is possible within a frame.

## Timing
- `BUSY` rises on the edge that samples the start bit. It falls on the edge that samples the stop bit.
- Frame length is N+2 sample edges with `PARITY`=0, and N+3 with `PARITY`=1.
- `Q`, `VALID` and `ERR` are registered. They change on the stop-bit sample edge itself; there are no extra pipeline stages.
- `VALID` and `ERR` stay high for exactly one `CLK` cycle and are never high together.
- With `ENB` tied to 1, back-to-back frames are accepted with no idle bit between them.
- With `ENB` pulsed (e.g. 1 in 4 cycles), the FSM holds its state between pulses. `VALID` is still one `CLK` cycle wide.

## Test plan
1. N=4, PARITY=0, DIR=0, ENB=1. Send line bits 0,1,1,0,1,1 (start, d0..d3, stop). Required: `Q`=4'hB and `VALID`=1 for one cycle, on the 6th edge after the frame begins; `BUSY` high for edges 1–5.
2. Same bit stream with DIR=1 (MSB first). Required: `Q`=4'hD and a `VALID` strobe.
3. PARITY=1, DIR=0. Data 4'hB sent with parity bit 1, then with parity bit 0. Required: the first frame gives `VALID` with `Q`=4'hB; the second gives `ERR` with `Q` still 4'hB.
4. Framing error: frame for 4'h5 with stop bit 0, then line held at 1. Required: `ERR` strobe, `Q` unchanged, FSM in IDLE, `BUSY`=0, and no spurious frame starts.
5. ENB=1 every 3rd cycle, two back-to-back frames 4'h3 and 4'hC. Required: two `VALID` strobes, each one cycle wide, with `Q`=4'h3 then `Q`=4'hC; the state holds between enables.
6. Assert `RST` after the 2nd data bit of a frame, release it, then send 4'h9. Required: `Q`=0 during reset and no strobe; the next frame gives `Q`=4'h9 with `VALID`.
